pattern_timer_fsm: RTL
======================

# pattern_timer_fsm

Parametrised start-pattern detector and timer-sequencing controller for serial-input timer blocks. It searches a serial `data` stream for a configurable start pattern, then asserts `shift_ena` for a fixed number of cycles while capturing those bits as a delay field. It then holds `counting` until the external counter reports completion, and holds `done` until the user acknowledges. Compared with the previous fixed 1101/4-bit controller, it adds pattern and shift-length parameters, on-chip capture of the shifted field, abort, an ack timeout and a counting-cycle monitor.

## Interface
- `PATTERN_W`, 4: start pattern length in bits, ≥2.
- `PATTERN`, 4'b1101: start pattern; first-received bit is the MSB.
- `SHIFT_CYCLES`, 4: cycles of `shift_ena` (bits captured), ≥1.
- `CNT_W`, 16: width of the counting-cycle monitor.
- `ACK_TIMEOUT`, 0: maximum cycles in DONE without `ack`; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `data`  in  1  serial input, sampled every cycle.
- `done_counting`  in  1  external counter finished.
- `ack`  in  1  user acknowledge of `done`.
- `abort`  in  1  synchronous abort, returns to SEARCH.
- `shift_ena`  out  1  high during SHIFT.
- `counting`  out  1  high during COUNT.
- `done`  out  1  high during DONE.
- `timeout`  out  1  one-cycle pulse on ack timeout.
- `shift_data`  out  SHIFT_CYCLES  captured field, first bit in the MSB.
- `count_cycles`  out  CNT_W  cycles spent in the current/last COUNT, saturating.

## Operation
- States: SEARCH, SHIFT, COUNT, DONE. `shift_ena`, `counting` and `done` are registered Moore outputs decoded from state.
- **SEARCH:**
  - Shift `data` into a PATTERN_W-bit history register.
  - A fill counter saturates at PATTERN_W and is cleared on entry to SEARCH, so a full fresh pattern is always required.
  - Match condition: fill ≥ PATTERN_W−1 and {history[PATTERN_W-2:0], data} == PATTERN. On match, go to SHIFT.
- **SHIFT:**
  - Each cycle, `shift_data` <= {shift_data[SHIFT_CYCLES-2:0], data}; for SHIFT_CYCLES=1, load `data` directly.
  - An internal counter runs 0..SHIFT_CYCLES−1. At the last value, go to COUNT.
  - `shift_data` is cleared on SHIFT entry and held stable outside SHIFT.
- **COUNT:**
  - `count_cycles` is cleared on entry, then increments every COUNT cycle and saturates at all-ones.
  - When `done_counting`=1, go to DONE. `count_cycles` holds after exit.
- **DONE:**
  - When `ack`=1, go to SEARCH.
  - If ACK_TIMEOUT>0 and ACK_TIMEOUT cycles elapse in DONE without `ack`: pulse `timeout` for one cycle and go to SEARCH.
  - `ack` in the same cycle as the timeout wins; no `timeout` pulse is produced.
- **Priority:** `reset_n`=0 first, then `abort`=1 (any state goes to SEARCH, clearing history, fill and the shift counter), then normal transitions.
- **Ignored inputs:**
  - `done_counting` outside COUNT.
  - `ack` outside DONE.
  - `data` outside SEARCH/SHIFT.

## Timing
- **Reset** (`reset_n` low at an edge): state=SEARCH; `shift_ena`, `counting`, `done` and `timeout` = 0; `shift_data`=0; `count_cycles`=0; history and fill cleared. Reset mid-sequence aborts without a `timeout` pulse.
- **Match:** if the last pattern bit is sampled at edge t, `shift_ena`=1 from after t through SHIFT_CYCLES cycles. The first captured bit is `data` at edge t+1.
- **SHIFT to COUNT:** `counting` rises the cycle after the last `shift_ena` cycle. There are no gap cycles.
- **COUNT to DONE:** if `done_counting` is sampled high at edge c, `counting`=0 and `done`=1 after c.
- **DONE to SEARCH:** if `ack` is sampled at edge a, `done`=0 after a. The search needs a full new pattern starting with `data` at edge a+1; the earliest match is at edge a+PATTERN_W.
- **Timeout:** `timeout` is high in the first cycle after leaving DONE by timeout, concurrent with SEARCH.
- **Abort:** takes effect at the sampling edge, and outputs drop the next cycle. An abort in SEARCH on the pattern's last-bit edge suppresses the match.

## Test plan
- **Defaults, basic sequence:**
  - Stimulus: `data` 1,1,0,1 then 1,0,1,0; `done_counting` after 5 COUNT cycles; `ack` 2 cycles later.
  - Required: `shift_ena` high exactly 4 cycles; `shift_data`=4'b1010; `count_cycles`=5; `done` high 3 cycles, then SEARCH.
- **Overlap and refill:**
  - Stimulus: `data` 1,1,1,0,1.
  - Required: match on the 5th bit, and no match before.
  - After `ack`, the stream 1,0,1 (old history 1 plus 101) must not match; a fresh 1,1,0,1 must match.
- **Abort mid-SHIFT:**
  - Stimulus: `abort` on the 2nd SHIFT cycle.
  - Required: `shift_ena`=0 next cycle; state SEARCH; no `counting`.
- **Timeout** (ACK_TIMEOUT=3):
  - With no `ack`: `done` high 3 cycles, then `timeout` pulses 1 cycle and the block is in SEARCH.
  - With `ack` on the 3rd DONE cycle: no `timeout`.
- **Parameter sweep** (PATTERN_W=6, PATTERN=6'b101100, SHIFT_CYCLES=1, CNT_W=3):
  - Correct match with `shift_ena` high 1 cycle.
  - `count_cycles` saturates at 7 for a 10-cycle COUNT.
- **Reset mid-COUNT:**
  - Stimulus: `reset_n`=0 for 1 cycle during COUNT.
  - Required: all outputs at reset values; `done_counting` afterwards is ignored.

Source files
------------

// File: rtl/pattern_timer_fsm.sv
`default_nettype none
// ============================================================================
// pattern_timer_fsm: serial start-pattern detector and timer sequencing FSM
// Revision: 1.0
// ============================================================================
module pattern_timer_fsm #(
  parameter int unsigned          PATTERN_W    = 4,
  parameter logic [PATTERN_W-1:0] PATTERN      = 4'b1101,
  parameter int unsigned          SHIFT_CYCLES = 4,
  parameter int unsigned          CNT_W        = 16,
  parameter int unsigned          ACK_TIMEOUT  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    data,
  input  logic                    done_counting,
  input  logic                    ack,
  input  logic                    abort,
  output logic                    shift_ena,
  output logic                    counting,
  output logic                    done,
  output logic                    timeout,
  output logic [SHIFT_CYCLES-1:0] shift_data,
  output logic [CNT_W-1:0]        count_cycles
);

  localparam int unsigned FILL_W = $clog2(PATTERN_W + 1);
  localparam int unsigned SCNT_W = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam int unsigned TMR_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [FILL_W-1:0] c_fill_max   = FILL_W'(PATTERN_W);
  localparam logic [FILL_W-1:0] c_fill_armed = FILL_W'(PATTERN_W - 1);
  localparam logic [SCNT_W-1:0] c_shift_last = SCNT_W'(SHIFT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  c_tmr_last   = TMR_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam bit                c_tmo_en     = (ACK_TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_SHIFT  = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [PATTERN_W-2:0]    history_q, history_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [SCNT_W-1:0]       shift_cnt_q, shift_cnt_d;
  logic [SHIFT_CYCLES-1:0] shift_data_q, shift_data_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic                    shift_ena_q, shift_ena_d;
  logic                    counting_q, counting_d;
  logic                    done_q, done_d;
  logic                    timeout_q, timeout_d;

  // Candidate windows including the bit being sampled this cycle.
  logic [PATTERN_W-1:0]    hist_window;
  logic [SHIFT_CYCLES:0]   shift_window;

  assign hist_window  = {history_q, data};
  assign shift_window = {shift_data_q, data};

  always_comb begin
    state_d      = state_q;
    history_d    = history_q;
    fill_d       = fill_q;
    shift_cnt_d  = shift_cnt_q;
    shift_data_d = shift_data_q;
    count_d      = count_q;
    tmr_d        = '0;
    timeout_d    = 1'b0;

    unique case (state_q)
      S_SEARCH: begin
        history_d = hist_window[PATTERN_W-2:0];
        if (fill_q != c_fill_max) begin
          fill_d = fill_q + 1'b1;
        end
        if ((fill_q >= c_fill_armed) && (hist_window == PATTERN)) begin
          state_d      = S_SHIFT;
          shift_cnt_d  = '0;
          shift_data_d = '0;
        end
      end
      S_SHIFT: begin
        shift_data_d = shift_window[SHIFT_CYCLES-1:0];
        shift_cnt_d  = shift_cnt_q + 1'b1;
        if (shift_cnt_q == c_shift_last) begin
          state_d     = S_COUNT;
          shift_cnt_d = '0;
          count_d     = '0;
        end
      end
      S_COUNT: begin
        if (count_q != '1) begin
          count_d = count_q + 1'b1;
        end
        if (done_counting) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        tmr_d = tmr_q + 1'b1;
        // ack on the timeout cycle takes precedence and suppresses the pulse
        if (ack) begin
          state_d   = S_SEARCH;
          history_d = '0;
          fill_d    = '0;
        end else if (c_tmo_en && (tmr_q == c_tmr_last)) begin
          state_d   = S_SEARCH;
          history_d = '0;
          fill_d    = '0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = S_SEARCH;
      end
    endcase

    if (abort) begin
      state_d      = S_SEARCH;
      history_d    = '0;
      fill_d       = '0;
      shift_cnt_d  = '0;
      shift_data_d = shift_data_q;
      count_d      = count_q;
      tmr_d        = '0;
      timeout_d    = 1'b0;
    end

    shift_ena_d = (state_d == S_SHIFT);
    counting_d  = (state_d == S_COUNT);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_SEARCH;
      history_q    <= '0;
      fill_q       <= '0;
      shift_cnt_q  <= '0;
      shift_data_q <= '0;
      count_q      <= '0;
      tmr_q        <= '0;
      shift_ena_q  <= 1'b0;
      counting_q   <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      history_q    <= history_d;
      fill_q       <= fill_d;
      shift_cnt_q  <= shift_cnt_d;
      shift_data_q <= shift_data_d;
      count_q      <= count_d;
      tmr_q        <= tmr_d;
      shift_ena_q  <= shift_ena_d;
      counting_q   <= counting_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign shift_ena    = shift_ena_q;
  assign counting     = counting_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign shift_data   = shift_data_q;
  assign count_cycles = count_q;

endmodule
`default_nettype wire
